seg7_capture: RTL and testbench
===============================

# seg7_capture

On-chip receiver for the seven-segment output bus driven by the UABC Mexicali user design. It samples a 7-bit segment pattern, filters glitches and multiplex transitions with a stability window, and decodes each newly settled pattern back to a hex nibble. Results are handed out over a valid/ready handshake. It sits on the far end of `uo_out[6:0]` as a loopback self-check and readback path, replacing visual inspection of the display.

## Interface
Parameters:
- `STABLE_CYCLES`, default 4. Number of consecutive identical samples required to accept a pattern. Legal range is 2..15.
- `CNT_W`, default 8. Width of the event counter.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset, synchronous and active-high.
- `ena` in 1: sampling enable. While low, all state freezes.
- `seg_in` in 7: segment pattern, bit0 = a … bit6 = g, active-high.
- `out_valid` out 1: a decoded event is held.
- `out_ready` in 1: the consumer accepts the held event.
- `digit` out 4: decoded hex value.
- `blank` out 1: the event pattern was 0x00.
- `bad_pattern` out 1: the event pattern is neither a hex glyph nor blank.
- `overrun` out 1: sticky flag; an event was dropped while `out_valid` was high.
- `evt_count` out `CNT_W`: count of accepted events, wraps modulo 2^`CNT_W`.

## Operation
- Input register `seg_q` captures `seg_in` every cycle in which `ena` is high.
- Stability counter `stab`, 4 bits:
  - Cleared when `seg_q` changes.
  - Otherwise increments, saturating at `STABLE_CYCLES`.
- FSM states:
  - SETTLE → LOCKED when `stab` reaches `STABLE_CYCLES-1` with an unchanged sample, i.e. the pattern has been seen `STABLE_CYCLES` times in a row.
  - LOCKED → SETTLE on any change of `seg_q`.
  - Reset state is SETTLE.
- On entering LOCKED, compare the pattern with `last_pat`:
  - `last_pat` is 7 bits plus a `have_last` flag; `have_last` is cleared by reset.
  - If `have_last` is 0 or the pattern differs, an event fires. Otherwise nothing happens, so a glitch that returns to the same pattern produces no event.
- Event handling:
  - `last_pat` updates to the new pattern.
  - `evt_count` increments.
  - If `out_valid` is 0, or `out_valid` and `out_ready` are both 1 in the same cycle, the output register loads `digit`, `blank`, `bad_pattern` and `out_valid` is set to 1.
  - Otherwise the event is dropped, `overrun` is set, and `evt_count` still increments.
- Decode (hex glyphs):
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07
  - 8:7F, 9:6F, A:77, b:7C, C:39, d:5E, E:79, F:71
- Decode (other patterns):
  - 0x00 gives `blank`=1, `digit`=0.
  - Any other pattern gives `bad_pattern`=1, `digit`=0.
- Handshake: `out_valid` clears on `out_ready` unless a new event loads in the same cycle.
- `overrun` clears only on `rst`.
- `ena`=0 freezes everything except the handshake, which still completes.

## Timing
- Reset values are all 0: every output, `stab`, `seg_q`, `have_last`; FSM in SETTLE.
- `rst` has priority over everything. A reset in mid-settle discards partial stability.
- Latency: `seg_in` holds a new value from edge N. `seg_q` updates at edge N. `out_valid` and data appear after edge N+`STABLE_CYCLES`, i.e. 4 cycles after `seg_q` changes with the defaults.
- A pattern held exactly `STABLE_CYCLES`-1 samples is never accepted.
- Throughput is at most one event per `STABLE_CYCLES` cycles.
- Simultaneous event and `out_ready`: the load wins, `out_valid` stays 1, and there is no overrun.

## Structure
- Package `seg7_pkg`:
  - the 16 glyph constants and `SEG_BLANK`;
  - the `seg7_evt_t` struct {`digit`, `blank`, `bad_pattern`};
  - the `STAB_W`=4 constant.
- Sub-module `seg7_decode`: a combinational pattern-to-`seg7_evt_t` decoder. It is reusable by the bench scoreboard.
- The top level holds the sampler, the stability FSM, the output register and the counter.

## Test plan
- Reset, then `seg_in`=0x06 steady → `out_valid`=1 with `digit`=1 exactly 4 cycles after `seg_q`=0x06; `evt_count`=1.
- 0x06 → 0x5B held 3 samples → 0x06 → no new event; `evt_count` stays 1; FSM returns to LOCKED.
- Sweep all 16 glyphs plus 0x00 and 0x55, each held 6 cycles, `out_ready`=1 → `digit` 0..F in order, then `blank`=1, then `bad_pattern`=1; `evt_count`=18.
- `out_ready`=0, patterns 0x3F, 0x06, 0x5B → the first is held, `overrun`=1 after the second; `out_ready` pulse yields `digit`=0 only.
- `CNT_W`=2, five distinct events → `evt_count` sequence 1, 2, 3, 0, 1.
- `rst` asserted 2 cycles into settling on 0x4F → no event; after release, 0x4F yields an event because `have_last` was cleared.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment capture path: glyph table,
// decoded event record and stability counter width.
package seg7_pkg;

  localparam int STAB_W = 4;

  // Segment order is {g,f,e,d,c,b,a}, active-high.
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef struct packed {
    logic [3:0] digit;
    logic       blank;
    logic       bad_pattern;
  } seg7_evt_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational seven-segment pattern to hex event decoder.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg_i,
  output seg7_evt_t  evt_o
);

  // Glyph lookup; blank and non-glyph patterns both report digit 0.
  always_comb begin
    evt_o.digit       = 4'h0;
    evt_o.blank       = 1'b0;
    evt_o.bad_pattern = 1'b0;
    case (seg_i)
      SEG_0:     evt_o.digit = 4'h0;
      SEG_1:     evt_o.digit = 4'h1;
      SEG_2:     evt_o.digit = 4'h2;
      SEG_3:     evt_o.digit = 4'h3;
      SEG_4:     evt_o.digit = 4'h4;
      SEG_5:     evt_o.digit = 4'h5;
      SEG_6:     evt_o.digit = 4'h6;
      SEG_7:     evt_o.digit = 4'h7;
      SEG_8:     evt_o.digit = 4'h8;
      SEG_9:     evt_o.digit = 4'h9;
      SEG_A:     evt_o.digit = 4'hA;
      SEG_B:     evt_o.digit = 4'hB;
      SEG_C:     evt_o.digit = 4'hC;
      SEG_D:     evt_o.digit = 4'hD;
      SEG_E:     evt_o.digit = 4'hE;
      SEG_F:     evt_o.digit = 4'hF;
      SEG_BLANK: evt_o.blank = 1'b1;
      default:   evt_o.bad_pattern = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_capture.sv
// Seven-segment bus receiver: samples, waits for a stable pattern, decodes
// each newly settled pattern and offers it on a valid/ready output.
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [6:0]       seg_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       digit,
  output logic             blank,
  output logic             bad_pattern,
  output logic             overrun,
  output logic [CNT_W-1:0] evt_count
);

  localparam logic [1:0] ST_SETTLE = 2'd0;
  localparam logic [1:0] ST_LOCKED = 2'd1;

  localparam logic [STAB_W-1:0] STAB_MAX  = STAB_W'(STABLE_CYCLES);
  // Lock on the edge where stab would reach STABLE_CYCLES-1.
  localparam logic [STAB_W-1:0] STAB_LOCK = STAB_W'(STABLE_CYCLES - 2);
  localparam logic [STAB_W-1:0] STAB_ONE  = STAB_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  logic [6:0]        seg_q, seg_d;
  logic [STAB_W-1:0] stab_q, stab_d;
  logic [1:0]        state_q, state_d;
  logic [6:0]        last_pat_q, last_pat_d;
  logic              have_last_q, have_last_d;
  logic              pend_q, pend_d;
  logic [6:0]        pend_pat_q, pend_pat_d;
  seg7_evt_t         evt_q, evt_d;
  logic              valid_q, valid_d;
  logic              overrun_q, overrun_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              seg_changed_s;
  logic              lock_s;
  logic              new_evt_s;
  logic              fire_s;
  logic              load_s;
  seg7_evt_t         dec_evt_s;

  seg7_decode u_decode (
    .seg_i (pend_pat_q),
    .evt_o (dec_evt_s)
  );

  // Settle detection and event qualification against the last accepted pattern.
  always_comb begin
    seg_changed_s = (seg_in != seg_q);
    lock_s        = ena && (state_q == ST_SETTLE) && !seg_changed_s && (stab_q == STAB_LOCK);
    new_evt_s     = lock_s && (!have_last_q || (seg_q != last_pat_q));
    fire_s        = ena && pend_q;
    load_s        = fire_s && (!valid_q || out_ready);
  end

  // Next-state logic for sampler, FSM, last pattern, output register and counter.
  always_comb begin
    seg_d       = seg_q;
    stab_d      = stab_q;
    state_d     = state_q;
    last_pat_d  = last_pat_q;
    have_last_d = have_last_q;
    pend_d      = pend_q;
    pend_pat_d  = pend_pat_q;
    evt_d       = evt_q;
    valid_d     = valid_q;
    overrun_d   = overrun_q;
    cnt_d       = cnt_q;

    if (ena) begin
      seg_d  = seg_in;
      pend_d = new_evt_s;
      if (seg_changed_s) begin
        stab_d = '0;
      end else if (stab_q != STAB_MAX) begin
        stab_d = stab_q + STAB_ONE;
      end else begin
        stab_d = stab_q;
      end
      case (state_q)
        ST_SETTLE: state_d = lock_s ? ST_LOCKED : ST_SETTLE;
        ST_LOCKED: state_d = seg_changed_s ? ST_SETTLE : ST_LOCKED;
        default:   state_d = ST_SETTLE;
      endcase
    end else begin
      seg_d = seg_q;
    end

    if (new_evt_s) begin
      last_pat_d  = seg_q;
      have_last_d = 1'b1;
      pend_pat_d  = seg_q;
    end else begin
      last_pat_d  = last_pat_q;
    end

    // The handshake keeps working while sampling is frozen.
    if (fire_s) begin
      cnt_d = cnt_q + CNT_ONE;
      if (load_s) begin
        evt_d   = dec_evt_s;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q       <= 7'h00;
      stab_q      <= '0;
      state_q     <= ST_SETTLE;
      last_pat_q  <= 7'h00;
      have_last_q <= 1'b0;
      pend_q      <= 1'b0;
      pend_pat_q  <= 7'h00;
      evt_q       <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      seg_q       <= seg_d;
      stab_q      <= stab_d;
      state_q     <= state_d;
      last_pat_q  <= last_pat_d;
      have_last_q <= have_last_d;
      pend_q      <= pend_d;
      pend_pat_q  <= pend_pat_d;
      evt_q       <= evt_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid   = valid_q;
  assign digit       = evt_q.digit;
  assign blank       = evt_q.blank;
  assign bad_pattern = evt_q.bad_pattern;
  assign overrun     = overrun_q;
  assign evt_count   = cnt_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Bench for seg7_capture: run-length reference model plus directed and random stimulus.
module tb_seg7_capture;

  localparam int SC = 4;

  logic       clk = 1'b0;
  logic       rst, ena, out_ready;
  logic [6:0] seg_in;

  logic       out_valid, blank, bad_pattern, overrun;
  logic [3:0] digit;
  logic [7:0] evt_count;
  logic       v2, b2, bad2, ovr2;
  logic [3:0] d2;
  logic [1:0] cnt2;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  logic [6:0] glyph [16];

  // Reference model state
  bit         m_valid, m_blank, m_bad, m_overrun, m_pend, m_have_last, m_loaded;
  logic [3:0] m_digit;
  logic [6:0] m_seg, m_last, m_pend_pat;
  int         m_run, m_count;

  seg7_capture #(.STABLE_CYCLES(SC), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .ena(ena), .seg_in(seg_in),
    .out_valid(out_valid), .out_ready(out_ready), .digit(digit),
    .blank(blank), .bad_pattern(bad_pattern), .overrun(overrun),
    .evt_count(evt_count)
  );

  seg7_capture #(.STABLE_CYCLES(SC), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .ena(ena), .seg_in(seg_in),
    .out_valid(v2), .out_ready(out_ready), .digit(d2),
    .blank(b2), .bad_pattern(bad2), .overrun(ovr2),
    .evt_count(cnt2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] model_decode(input logic [6:0] p);
    if (p == 7'h00) return {4'h0, 1'b1, 1'b0};
    for (int k = 0; k < 16; k++) begin
      if (glyph[k] == p) return {4'(k), 1'b0, 1'b0};
    end
    return {4'h0, 1'b0, 1'b1};
  endfunction

  // Model: a pattern is accepted on its SC-th consecutive enabled sample and
  // appears on the output at the following enabled sample.
  task automatic model_step();
    if (rst) begin
      m_valid = 0; m_blank = 0; m_bad = 0; m_overrun = 0; m_pend = 0;
      m_have_last = 0; m_digit = 4'h0; m_seg = 7'h00; m_last = 7'h00;
      m_pend_pat = 7'h00; m_run = 1; m_count = 0;
    end else begin
      m_loaded = 0;
      if (ena && m_pend) begin
        m_count++;
        if (!m_valid || out_ready) begin
          {m_digit, m_blank, m_bad} = model_decode(m_pend_pat);
          m_valid  = 1;
          m_loaded = 1;
        end else begin
          m_overrun = 1;
        end
      end
      if (!m_loaded && m_valid && out_ready) m_valid = 0;
      if (ena) begin
        if (seg_in == m_seg) begin
          if (m_run < 100) m_run++;
        end else begin
          m_seg = seg_in;
          m_run = 1;
        end
        m_pend = 0;
        if (m_run == SC && (!m_have_last || m_seg != m_last)) begin
          m_pend      = 1;
          m_pend_pat  = m_seg;
          m_last      = m_seg;
          m_have_last = 1;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle compare of both instances against the model.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("valid", out_valid, m_valid);
      check("overrun", overrun, m_overrun);
      check("count", evt_count, m_count % 256);
      check("valid2", v2, m_valid);
      check("overrun2", ovr2, m_overrun);
      check("count2", cnt2, m_count % 4);
      if (m_valid) begin
        check("digit", digit, m_digit);
        check("blank", blank, m_blank);
        check("bad", bad_pattern, m_bad);
        check("digit2", d2, m_digit);
        check("bad2", {b2, bad2}, {m_blank, m_bad});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    int exp_cnt2 [5];
    logic [6:0] pat;
    glyph = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    exp_cnt2 = '{1, 2, 3, 0, 1};
    rst = 1'b1; ena = 1'b1; out_ready = 1'b0; seg_in = 7'h06;
    tick(2);
    chk_en = 1'b1;

    // Reset state and first-event latency
    check("rst_valid", out_valid, 0);
    check("rst_count", evt_count, 0);
    check("rst_overrun", overrun, 0);
    check("rst_digit", digit, 0);
    rst = 1'b0;
    tick(1);
    tick(3);
    check("lat_not_yet", out_valid, 0);
    tick(1);
    check("lat_valid", out_valid, 1);
    check("lat_digit", digit, 1);
    check("lat_count", evt_count, 1);

    // Short glitch back to the same pattern gives no event
    out_ready = 1'b1;
    seg_in = 7'h5B; tick(3);
    seg_in = 7'h06; tick(8);
    check("glitch_count", evt_count, 1);
    check("glitch_valid", out_valid, 0);

    // Sweep all glyphs, blank and a bad pattern
    do_reset();
    for (int i = 0; i < 18; i++) begin
      pat = (i < 16) ? glyph[i] : ((i == 16) ? 7'h00 : 7'h55);
      seg_in = pat;
      tick(5);
      check("sweep_valid", out_valid, 1);
      check("sweep_digit", digit, (i < 16) ? i : 0);
      check("sweep_blank", blank, (i == 16) ? 1 : 0);
      check("sweep_bad", bad_pattern, (i == 17) ? 1 : 0);
      tick(1);
    end
    check("sweep_count", evt_count, 18);
    check("sweep_count2", cnt2, 2);
    check("sweep_overrun", overrun, 0);

    // Overrun with a stalled consumer
    do_reset();
    out_ready = 1'b0;
    seg_in = 7'h3F; tick(6);
    check("ovr_first", overrun, 0);
    seg_in = 7'h06; tick(6);
    check("ovr_set", overrun, 1);
    seg_in = 7'h5B; tick(6);
    check("ovr_held_valid", out_valid, 1);
    check("ovr_held_digit", digit, 0);
    check("ovr_count", evt_count, 3);
    out_ready = 1'b1; tick(1); out_ready = 1'b0;
    check("ovr_drained", out_valid, 0);
    check("ovr_sticky", overrun, 1);

    // Narrow counter wraps
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      seg_in = glyph[k];
      tick(6);
      check("wrap_count2", cnt2, exp_cnt2[k]);
    end

    // Reset mid-settle discards partial stability and last pattern
    do_reset();
    seg_in = 7'h4F; tick(6);
    seg_in = 7'h5B; tick(2);
    seg_in = 7'h4F; tick(2);
    check("mid_pre_count", evt_count, 1);
    rst = 1'b1; tick(1); rst = 1'b0;
    check("mid_rst_count", evt_count, 0);
    tick(5);
    check("mid_event_count", evt_count, 1);
    check("mid_event_digit", digit, 3);

    // Randomised patterns, hold times, enable and ready
    do_reset();
    repeat (300) begin
      int r;
      int hold;
      r = $urandom_range(0, 19);
      if (r < 16) seg_in = glyph[r];
      else if (r == 16) seg_in = 7'h00;
      else seg_in = 7'($urandom_range(0, 127));
      hold = $urandom_range(1, 7);
      repeat (hold) begin
        ena = ($urandom_range(0, 9) != 0);
        out_ready = ($urandom_range(0, 2) != 0);
        tick(1);
      end
    end
    ena = 1'b1;
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
